// File: rtl/fp_align_add.sv
// Binary32 adder front end: unpack, magnitude swap, alignment with G/R/S, effective add/sub.
// Define FPADD_SPECIALS_EN to add NaN/infinity detection and the special_flag output.
module fp_align_add #(
    parameter int PIPE_STAGES = 2,
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          op_a,
    input  logic [31:0]          op_b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FPADD_SPECIALS_EN
    output logic [1:0]           special_flag,
`endif
    output logic [MAN_W:0]       aligned_result,
    output logic                 aligned_sign,
    output logic [EXP_W-1:0]     exponent_out,
    output logic                 guard_bit,
    output logic                 round_bit,
    output logic                 sticky_bit
);

    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(EXT_W);

    generate
        if (PIPE_STAGES != 2) begin : g_bad_stages
            $error("fp_align_add supports only PIPE_STAGES = 2");
        end
    endgenerate

    logic                 s1_valid;
    logic [EXT_W-1:0]     s1_big;
    logic [EXT_W-1:0]     s1_small;
    logic [EXP_W-1:0]     s1_exp;
    logic                 s1_sign;
    logic                 s1_eff_sub;
    logic                 s2_load;
    logic                 in_fire;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Stage 1 combinational: unpack, pick the larger magnitude, align the smaller one.
    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b, exp_big, exp_small, diff;
    logic [MAN_W-1:0] man_a, man_b;
    logic [SIG_W-1:0] sig_a, sig_b, sig_big, sig_small;
    logic [EXT_W-1:0] small_ext, small_shifted;
    logic             sign_a, sign_eff_b, a_big, sign_big, eff_sub;

    always_comb begin
        exp_a      = op_a[MAN_W +: EXP_W];
        exp_b      = op_b[MAN_W +: EXP_W];
        man_a      = op_a[MAN_W-1:0];
        man_b      = op_b[MAN_W-1:0];
        sign_a     = op_a[EXP_W+MAN_W];
        sign_eff_b = op_b[EXP_W+MAN_W] ^ sub;
        eexp_a     = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b     = (exp_b == '0) ? EXP_W'(1) : exp_b;
        sig_a      = {(exp_a != '0), man_a};
        sig_b      = {(exp_b != '0), man_b};
        a_big      = {exp_a, man_a} >= {exp_b, man_b};
        sig_big    = a_big ? sig_a : sig_b;
        sig_small  = a_big ? sig_b : sig_a;
        exp_big    = a_big ? eexp_a : eexp_b;
        exp_small  = a_big ? eexp_b : eexp_a;
        sign_big   = a_big ? sign_a : sign_eff_b;
        eff_sub    = sign_a ^ sign_eff_b;
        diff       = exp_big - exp_small;
        small_ext  = {sig_small, 3'b000};
        if (diff >= SHIFT_MAX) begin
            small_shifted = {{(EXT_W-1){1'b0}}, (sig_small != '0)};
        end else begin
            small_shifted    = small_ext >> diff;
            small_shifted[0] = small_shifted[0] | (|(small_ext & ~({EXT_W{1'b1}} << diff)));
        end
    end

`ifdef FPADD_SPECIALS_EN
    logic [1:0] spec_c, s1_special;
    logic       spec_sign_c, s1_spec_sign;
    logic       nan_a, nan_b, inf_a, inf_b;

    // inf - inf under an effective subtract has no meaningful value, so it joins the NaN case.
    always_comb begin
        nan_a       = (exp_a == '1) && (man_a != '0);
        nan_b       = (exp_b == '1) && (man_b != '0);
        inf_a       = (exp_a == '1) && (man_a == '0);
        inf_b       = (exp_b == '1) && (man_b == '0);
        spec_c      = 2'b00;
        spec_sign_c = 1'b0;
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
            spec_c = 2'b10;
        end else if (inf_a || inf_b) begin
            spec_c      = 2'b01;
            spec_sign_c = inf_a ? sign_a : sign_eff_b;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_big     <= '0;
            s1_small   <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_eff_sub <= 1'b0;
`ifdef FPADD_SPECIALS_EN
            s1_special   <= 2'b00;
            s1_spec_sign <= 1'b0;
`endif
        end else begin
            if (in_fire) begin
                s1_valid   <= 1'b1;
                s1_big     <= {sig_big, 3'b000};
                s1_small   <= small_shifted;
                s1_exp     <= exp_big;
                s1_sign    <= sign_big;
                s1_eff_sub <= eff_sub;
`ifdef FPADD_SPECIALS_EN
                s1_special   <= spec_c;
                s1_spec_sign <= spec_sign_c;
`endif
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 combinational: add/sub, fold a carry back into 27 bits, force clean zeros.
    logic [EXT_W:0]   sum;
    logic [EXT_W-1:0] norm;
    logic [EXP_W-1:0] exp_n;
    logic             sign_n;
    logic [SIG_W-1:0] res_n;
    logic [2:0]       grs_n;

    always_comb begin
        sum = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                         : ({1'b0, s1_big} + {1'b0, s1_small});
        if (sum[EXT_W]) begin
            norm  = {sum[EXT_W:2], sum[1] | sum[0]};
            exp_n = s1_exp + 1'b1;
        end else begin
            norm  = sum[EXT_W-1:0];
            exp_n = s1_exp;
        end
        sign_n = s1_sign;
        res_n  = norm[EXT_W-1:3];
        grs_n  = norm[2:0];
        if (sum == '0) begin
            exp_n  = '0;
            sign_n = 1'b0;
        end
`ifdef FPADD_SPECIALS_EN
        if (s1_special == 2'b10) begin
            res_n  = {2'b11, {(SIG_W-2){1'b0}}};
            exp_n  = '1;
            sign_n = 1'b0;
            grs_n  = 3'b000;
        end else if (s1_special == 2'b01) begin
            res_n  = {1'b1, {(SIG_W-1){1'b0}}};
            exp_n  = '1;
            sign_n = s1_spec_sign;
            grs_n  = 3'b000;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            aligned_result <= '0;
            aligned_sign   <= 1'b0;
            exponent_out   <= '0;
            guard_bit      <= 1'b0;
            round_bit      <= 1'b0;
            sticky_bit     <= 1'b0;
`ifdef FPADD_SPECIALS_EN
            special_flag   <= 2'b00;
`endif
        end else begin
            if (s2_load) begin
                out_valid      <= 1'b1;
                aligned_result <= res_n;
                aligned_sign   <= sign_n;
                exponent_out   <= exp_n;
                guard_bit      <= grs_n[2];
                round_bit      <= grs_n[1];
                sticky_bit     <= grs_n[0];
`ifdef FPADD_SPECIALS_EN
                special_flag   <= s1_special;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: directed vectors, backpressure, reset, and random
// traffic checked against an arithmetic reference model.
module tb_fp_align_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] aligned_result;
    logic        aligned_sign;
    logic [7:0]  exponent_out;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
`ifdef FPADD_SPECIALS_EN
    logic [1:0]  special_flag;
`endif
    logic [35:0] observed;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign observed = {aligned_sign, exponent_out, aligned_result, guard_bit, round_bit, sticky_bit};

    fp_align_add dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .sub            (sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef FPADD_SPECIALS_EN
        .special_flag   (special_flag),
`endif
        .aligned_result (aligned_result),
        .aligned_sign   (aligned_sign),
        .exponent_out   (exponent_out),
        .guard_bit      (guard_bit),
        .round_bit      (round_bit),
        .sticky_bit     (sticky_bit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer arithmetic on significands scaled by 8 (three extra low bits).
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sig_a, sig_b, big_v, small_v, al, sum, scale;
        int     ea, eb, e_big, d;
        logic   a_big, eff_sub, sign_big;
        ea       = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb       = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        sig_a    = longint'(a[22:0]) + ((a[30:23] != 8'd0) ? (longint'(1) << 23) : 0);
        sig_b    = longint'(b[22:0]) + ((b[30:23] != 8'd0) ? (longint'(1) << 23) : 0);
        a_big    = (a[30:0] >= b[30:0]);
        eff_sub  = a[31] ^ b[31] ^ s;
        sign_big = a_big ? a[31] : (b[31] ^ s);
        big_v    = (a_big ? sig_a : sig_b) * 8;
        small_v  = (a_big ? sig_b : sig_a) * 8;
        e_big    = a_big ? ea : eb;
        d        = e_big - (a_big ? eb : ea);
        if (d >= 27) begin
            al = (small_v != 0) ? 1 : 0;
        end else begin
            scale = longint'(1) << d;
            al    = small_v / scale;
            if (al * scale != small_v) al = al | 1;
        end
        sum = eff_sub ? (big_v - al) : (big_v + al);
        if (sum >= (longint'(1) << 27)) begin
            sum   = ((sum % 4) != 0) ? ((sum / 2) | 1) : (sum / 2);
            e_big = (e_big + 1) % 256;
        end
        if (sum == 0) return 36'd0;
        return {sign_big, 8'(e_big), 24'(sum >> 3), sum[2], sum[1], sum[0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        int          k;
        k = int'($urandom_range(0, 9));
        m = 23'($urandom);
        case (k)
            0:       e = 8'd0;
            1:       e = 8'd254;
            2:       begin e = 8'($urandom_range(120, 134)); m = 23'd0; end
            3, 4, 5: e = 8'($urandom_range(120, 134));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, m};
    endfunction

    function automatic logic [31:0] rand_partner(input logic [31:0] a);
        if ($urandom_range(0, 3) == 0)
            return {1'($urandom), a[30:23], a[22:0] ^ 23'($urandom_range(0, 15))};
        return rand_op();
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (observed !== 36'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", observed);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h7F000000, 32'h00000001, 32'h3F800001, 32'h80000000};
        logic [31:0] vb[9] = '{32'h3F800000, 32'h33800000, 32'h0D800000, 32'h40400000, 32'h3F800000,
                               32'h7F000000, 32'h00000001, 32'h3F800000, 32'h00000000};
        logic        vs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [35:0] ve[9] = '{{1'b0, 8'h80, 24'h800000, 3'b000},
                               {1'b0, 8'h7F, 24'h800000, 3'b100},
                               {1'b0, 8'h7F, 24'h800000, 3'b001},
                               {1'b1, 8'h80, 24'h800000, 3'b000},
                               36'd0,
                               {1'b0, 8'hFF, 24'h800000, 3'b000},
                               {1'b0, 8'h01, 24'h000002, 3'b000},
                               {1'b0, 8'h7F, 24'h000001, 3'b000},
                               36'd0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            op_a     = va[i];
            op_b     = vb[i];
            sub      = vs[i];
            in_valid = 1'b1;
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            tests_run++;
            if (lat != 2) begin
                tests_failed++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected 2", i, lat);
            end
            tests_run++;
            if (observed !== ve[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, observed, ve[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[3], pb[3];
        logic        ps[3];
        logic [35:0] q[$];
        int          idx = 0;
        int          got = 0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_partner(pa[i]);
            ps[i] = 1'($urandom);
        end
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 3);
            op_a     = pa[idx % 3];
            op_b     = pb[idx % 3];
            sub      = ps[idx % 3];
            @(negedge clk);
            if (cyc >= 2) begin
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_in_ready_drop[%0d]: got %b expected 0", cyc, in_ready);
                end
                tests_run++;
                if (out_valid !== 1'b1 || q.size() == 0 || observed !== q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_hold[%0d]: got %b/%h expected 1/%h", cyc, out_valid, observed,
                             (q.size() != 0) ? q[0] : 36'd0);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(pa[idx], pb[idx], ps[idx]));
                idx++;
            end
            tick();
        end
        tests_run++;
        if (idx != 2) begin
            tests_failed++;
            $display("[TB] FAIL bp_accepted: got %0d expected 2", idx);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            in_valid = (idx < 3);
            op_a     = pa[idx % 3];
            op_b     = pb[idx % 3];
            sub      = ps[idx % 3];
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(pa[idx], pb[idx], ps[idx]));
                idx++;
            end
            if (out_valid) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_extra_output: got %h expected none", observed);
                end else begin
                    if (observed !== q[0]) begin
                        tests_failed++;
                        $display("[TB] FAIL bp_order[%0d]: got %h expected %h", got, observed, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != 3) begin
            tests_failed++;
            $display("[TB] FAIL bp_count: got %0d expected 3", got);
        end
        drain();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_duplicate: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [35:0] q[$];
        logic [31:0] a, b;
        logic        s;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        out_ready = 1'b1;
        a = rand_op();
        b = rand_partner(a);
        s = 1'($urandom);
        while (got < n && cyc < n + 20) begin
            in_valid = (sent < n);
            op_a     = a;
            op_b     = b;
            sub      = s;
            @(negedge clk);
            if (in_valid) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", cyc, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, s));
                sent++;
                a = rand_op();
                b = rand_partner(a);
                s = 1'($urandom);
            end
            if (out_valid) begin
                tests_run++;
                if (q.size() == 0 || observed !== q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", got, observed,
                             (q.size() != 0) ? q[0] : 36'd0);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (cyc != n + 2 || got != n) begin
            tests_failed++;
            $display("[TB] FAIL b2b_throughput: got %0d cycles/%0d results expected %0d/%0d", cyc, got, n + 2, n);
        end
        drain();
    endtask

    task automatic test_random(input int n);
        logic [35:0] q[$];
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        logic        s = 1'b0;
        logic        pending = 1'b0;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        while (got < n && cyc < n * 20) begin
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                a = rand_op();
                b = rand_partner(a);
                s = 1'($urandom);
                pending = 1'b1;
            end
            in_valid  = pending;
            op_a      = a;
            op_b      = b;
            sub       = s;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, s));
                sent++;
                pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (q.size() == 0 || observed !== q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL random_result[%0d]: got %h expected %h (a=%h b=%h)", got, observed,
                             (q.size() != 0) ? q[0] : 36'd0, a, b);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (got != n) begin
            tests_failed++;
            $display("[TB] FAIL random_timeout: got %0d results expected %0d", got, n);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        op_a      = 32'h3F800000;
        op_b      = 32'h40000000;
        sub       = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || observed !== 36'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_flush: got %b/%h expected 0/0", out_valid, observed);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midreset_ghost[%0d]: got %b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back(16);
        test_random(300);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
